// File: rtl/pic_pkg.sv
// Shared types and priority helpers for the interrupt controller's acknowledge path.
// IR0 is the highest priority, so "highest priority" always means "lowest set index".
package pic_pkg;

    localparam int N_IR = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2,
        ACK2 = 2'd3
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } prio_t;

    // Lowest set index of vec; valid is clear when vec is all zeros.
    function automatic prio_t prio_idx(input logic [N_IR-1:0] vec);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        for (int i = N_IR - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

    // Levels strictly above the highest in-service level; all ones when nothing is in service.
    function automatic logic [N_IR-1:0] prio_mask(input logic [N_IR-1:0] isr);
        logic [N_IR-1:0] m;
        logic            seen;
        m    = '0;
        seen = 1'b0;
        for (int i = 0; i < N_IR; i++) begin
            if (isr[i]) begin
                seen = 1'b1;
            end
            m[i] = ~seen;
        end
        return m;
    endfunction

    function automatic logic [N_IR-1:0] lvl_onehot(input logic [2:0] lvl);
        logic [N_IR-1:0] r;
        r      = '0;
        r[lvl] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/priority_resolver.sv
// Fixed-priority resolver: picks the highest pending request that outranks everything in service.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [N_IR-1:0] irr,
    input  logic [N_IR-1:0] isr,
    output logic            req_valid,
    output logic [2:0]      req_lvl
);

    prio_t pick;

    assign pick      = prio_idx(irr & prio_mask(isr));
    assign req_valid = pick.valid;
    assign req_lvl   = pick.idx;

endmodule

// File: rtl/inta_sequencer.sv
// Acknowledge-side controller: raises INT, runs the two-pulse INTA handshake,
// drives the vector byte and owns the in-service register.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int VEC_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IR-1:0]  irr,
    input  logic             inta_n,
    input  logic [VEC_W-1:0] vec_base,
    input  logic             aeoi,
    input  logic             eoi,
    input  logic             seoi,
    input  logic [2:0]       seoi_lvl,
    output logic             int_out,
    output logic [N_IR-1:0]  isr,
    output logic [N_IR-1:0]  irr_clr,
    output logic [7:0]       data_out,
    output logic             data_oe
);

    state_e          state_q, state_d;
    logic            inta_q;
    logic [N_IR-1:0] isr_q, isr_d;
    logic [N_IR-1:0] irr_clr_q, irr_clr_d;
    logic            int_out_q, int_out_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            data_oe_q, data_oe_d;
    logic [2:0]      lvl_q, lvl_d;
    logic            spur_q, spur_d;

    logic            req_valid;
    logic [2:0]      req_lvl;
    logic            inta_fall, inta_rise;
    logic [N_IR-1:0] isr_set, aeoi_clr, eoi_clr, seoi_clr;
    prio_t           eoi_top;

    priority_resolver u_resolver (
        .irr       (irr),
        .isr       (isr_q),
        .req_valid (req_valid),
        .req_lvl   (req_lvl)
    );

    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;

    always_comb begin
        state_d    = state_q;
        int_out_d  = int_out_q;
        irr_clr_d  = '0;
        data_oe_d  = 1'b0;
        data_out_d = 8'h00;
        lvl_d      = lvl_q;
        spur_d     = spur_q;
        isr_set    = '0;
        aeoi_clr   = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = REQ;
                    int_out_d = 1'b1;
                end
            end
            REQ: begin
                // The request is re-resolved at the first fall; if it vanished, answer with level 7.
                if (inta_fall) begin
                    if (req_valid) begin
                        lvl_d     = req_lvl;
                        spur_d    = 1'b0;
                        isr_set   = lvl_onehot(req_lvl);
                        irr_clr_d = lvl_onehot(req_lvl);
                    end else begin
                        lvl_d  = 3'd7;
                        spur_d = 1'b1;
                    end
                    int_out_d = 1'b0;
                    state_d   = ACK1;
                end
            end
            ACK1: begin
                if (inta_fall) begin
                    state_d    = ACK2;
                    data_oe_d  = 1'b1;
                    data_out_d = {vec_base, lvl_q};
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_d = IDLE;
                    if (aeoi && !spur_q) begin
                        aeoi_clr = lvl_onehot(lvl_q);
                    end
                end else begin
                    data_oe_d  = 1'b1;
                    data_out_d = {vec_base, lvl_q};
                end
            end
            default: state_d = IDLE;
        endcase

        eoi_top  = prio_idx(isr_q);
        eoi_clr  = (eoi && eoi_top.valid) ? lvl_onehot(eoi_top.idx) : '0;
        seoi_clr = seoi ? lvl_onehot(seoi_lvl) : '0;

        // Clears act on the pre-edge value; a same-cycle acknowledge set of the same bit wins.
        isr_d = (isr_q & ~(eoi_clr | seoi_clr | aeoi_clr)) | isr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inta_q     <= 1'b1;
            isr_q      <= '0;
            irr_clr_q  <= '0;
            int_out_q  <= 1'b0;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
            lvl_q      <= 3'd0;
            spur_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inta_q     <= inta_n;
            isr_q      <= isr_d;
            irr_clr_q  <= irr_clr_d;
            int_out_q  <= int_out_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            lvl_q      <= lvl_d;
            spur_q     <= spur_d;
        end
    end

    assign int_out  = int_out_q;
    assign isr      = isr_q;
    assign irr_clr  = irr_clr_q;
    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed table of handshakes, hand-written corner sequences,
// then randomized transactions checked against a transaction-level priority model.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irr = 8'h00;
    logic       inta_n = 1'b1;
    logic [4:0] vb = 5'h11;
    logic       aeoi = 1'b0;
    logic       eoi = 1'b0;
    logic       seoi = 1'b0;
    logic [2:0] seoi_lvl = 3'd0;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] irr_clr;
    logic [7:0] data_out;
    logic       data_oe;

    int checks = 0;
    int errors = 0;

    inta_sequencer #(.VEC_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irr      (irr),
        .inta_n   (inta_n),
        .vec_base (vb),
        .aeoi     (aeoi),
        .eoi      (eoi),
        .seoi     (seoi),
        .seoi_lvl (seoi_lvl),
        .int_out  (int_out),
        .isr      (isr),
        .irr_clr  (irr_clr),
        .data_out (data_out),
        .data_oe  (data_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pre_eoi;
        logic       pre_seoi;
        logic [2:0] pre_lvl;
        logic [7:0] exp_pre;
        logic [7:0] irr;
        logic       aeoi;
        logic       exp_int;
        logic [7:0] exp_clr;
        logic [7:0] exp_mid;
        logic [7:0] exp_data;
        logic [7:0] exp_end;
    } vec_t;

    vec_t tbl [10];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Lowest set index, 8 when empty: IR0 outranks everything.
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    // Full two-pulse handshake, entered at a negedge with int_out already high.
    task automatic do_ack(input logic [7:0] e_clr, input logic [7:0] e_mid,
                          input logic [7:0] e_data, input logic [7:0] e_end,
                          input logic m_seoi, input logic [2:0] m_lvl);
        inta_n = 1'b0;
        step();
        chk("isr_after_fall1", {24'h0, isr}, {24'h0, e_mid});
        chk("irr_clr_pulse", {24'h0, irr_clr}, {24'h0, e_clr});
        chk("int_out_drop", {31'h0, int_out}, 32'h0);
        irr = 8'h00;
        step();
        chk("irr_clr_one_cycle", {24'h0, irr_clr}, 32'h0);
        inta_n = 1'b1;
        if (m_seoi) begin
            seoi     = 1'b1;
            seoi_lvl = m_lvl;
        end
        step();
        seoi = 1'b0;
        step();
        chk("data_oe_ack1", {31'h0, data_oe}, 32'h0);
        inta_n = 1'b0;
        step();
        chk("data_oe_on", {31'h0, data_oe}, 32'h1);
        chk("vector", {24'h0, data_out}, {24'h0, e_data});
        step();
        chk("vector_hold", {24'h0, data_out}, {24'h0, e_data});
        inta_n = 1'b1;
        step();
        chk("data_oe_off", {31'h0, data_oe}, 32'h0);
        chk("isr_after_rise2", {24'h0, isr}, {24'h0, e_end});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] m_isr;

        tbl[0] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h28, 1'b0, 1'b1, 8'h08, 8'h08, 8'h8B, 8'h08};
        tbl[1] = '{1'b0, 1'b1, 3'd3, 8'h00, 8'h04, 1'b0, 1'b1, 8'h04, 8'h04, 8'h8A, 8'h04};
        tbl[2] = '{1'b0, 1'b0, 3'd0, 8'h04, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h04};
        tbl[3] = '{1'b0, 1'b0, 3'd0, 8'h04, 8'h02, 1'b0, 1'b1, 8'h02, 8'h06, 8'h89, 8'h06};
        tbl[4] = '{1'b1, 1'b0, 3'd0, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h04};
        tbl[5] = '{1'b0, 1'b1, 3'd2, 8'h00, 8'h10, 1'b0, 1'b1, 8'h10, 8'h10, 8'h8C, 8'h10};
        tbl[6] = '{1'b0, 1'b0, 3'd0, 8'h10, 8'h04, 1'b0, 1'b1, 8'h04, 8'h14, 8'h8A, 8'h14};
        tbl[7] = '{1'b1, 1'b0, 3'd0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h10};
        tbl[8] = '{1'b0, 1'b1, 3'd4, 8'h00, 8'h40, 1'b1, 1'b1, 8'h40, 8'h40, 8'h8E, 8'h00};
        tbl[9] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state
        @(negedge clk);
        chk("rst_int_out", {31'h0, int_out}, 32'h0);
        chk("rst_isr", {24'h0, isr}, 32'h0);
        chk("rst_irr_clr", {24'h0, irr_clr}, 32'h0);
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
        chk("rst_data_oe", {31'h0, data_oe}, 32'h0);
        rst_n = 1'b1;
        step();

        // Directed table
        for (int r = 0; r < 10; r++) begin
            if (tbl[r].pre_eoi || tbl[r].pre_seoi) begin
                eoi      = tbl[r].pre_eoi;
                seoi     = tbl[r].pre_seoi;
                seoi_lvl = tbl[r].pre_lvl;
                step();
                eoi  = 1'b0;
                seoi = 1'b0;
            end
            chk("tbl_pre_isr", {24'h0, isr}, {24'h0, tbl[r].exp_pre});
            irr  = tbl[r].irr;
            aeoi = tbl[r].aeoi;
            vb   = 5'h11;
            step();
            chk("tbl_int_out", {31'h0, int_out}, {31'h0, tbl[r].exp_int});
            if (tbl[r].exp_int) begin
                do_ack(tbl[r].exp_clr, tbl[r].exp_mid, tbl[r].exp_data, tbl[r].exp_end, 1'b0, 3'd0);
            end else begin
                irr = 8'h00;
                step();
                chk("tbl_isr_hold", {24'h0, isr}, {24'h0, tbl[r].exp_end});
            end
            $display("row %0d irr=%02h isr=%02h", r, tbl[r].irr, isr);
        end

        // Spurious acknowledge with IR7 in service: no set, no clr pulse, AEOI must not retire IR7
        aeoi = 1'b0;
        irr  = 8'h80;
        step();
        chk("ir7_int_out", {31'h0, int_out}, 32'h1);
        do_ack(8'h80, 8'h80, 8'h8F, 8'h80, 1'b0, 3'd0);
        aeoi = 1'b1;
        irr  = 8'h01;
        step();
        chk("spur_int_out", {31'h0, int_out}, 32'h1);
        irr = 8'h00;
        step();
        chk("spur_int_held", {31'h0, int_out}, 32'h1);
        do_ack(8'h00, 8'h80, 8'h8F, 8'h80, 1'b0, 3'd0);
        aeoi     = 1'b0;
        seoi     = 1'b1;
        seoi_lvl = 3'd7;
        step();
        seoi = 1'b0;
        chk("seoi7_isr", {24'h0, isr}, 32'h0);
        $display("spurious sequence done isr=%02h", isr);

        // Asynchronous reset in the middle of ACK2
        irr = 8'h08;
        step();
        chk("rst_seq_int", {31'h0, int_out}, 32'h1);
        inta_n = 1'b0;
        step();
        irr = 8'h00;
        step();
        inta_n = 1'b1;
        step();
        step();
        inta_n = 1'b0;
        step();
        chk("rst_seq_oe_on", {31'h0, data_oe}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_oe", {31'h0, data_oe}, 32'h0);
        chk("async_rst_isr", {24'h0, isr}, 32'h0);
        chk("async_rst_int", {31'h0, int_out}, 32'h0);
        chk("async_rst_data", {24'h0, data_out}, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        inta_n = 1'b1;
        step();
        inta_n = 1'b0;
        step();
        step();
        chk("idle_ignores_inta_oe", {31'h0, data_oe}, 32'h0);
        chk("idle_ignores_inta_isr", {24'h0, isr}, 32'h0);
        inta_n = 1'b1;
        step();
        step();
        $display("reset sequence done isr=%02h", isr);

        // Randomized transactions against the priority model
        m_isr = 8'h00;
        for (int it = 0; it < 150; it++) begin
            int         op;
            logic [2:0] sl;
            logic [7:0] clr;
            logic       q;
            op = $urandom_range(0, 3);
            sl = 3'($urandom_range(0, 7));
            if (op != 0) begin
                eoi      = op[0];
                seoi     = op[1];
                seoi_lvl = sl;
                step();
                eoi  = 1'b0;
                seoi = 1'b0;
                clr  = 8'h00;
                if (op[0] && m_isr != 8'h00) clr = clr | (8'd1 << lowest(m_isr));
                if (op[1]) clr = clr | (8'd1 << sl);
                m_isr = m_isr & ~clr;
                chk("rnd_eoi_isr", {24'h0, isr}, {24'h0, m_isr});
            end
            irr  = 8'($urandom & $urandom);
            aeoi = 1'($urandom);
            vb   = 5'($urandom);
            step();
            q = (lowest(irr) < lowest(m_isr));
            chk("rnd_int_out", {31'h0, int_out}, {31'h0, q});
            if (q) begin
                int         l;
                logic [7:0] mid, e_end;
                logic       ms;
                logic [2:0] ml;
                l     = lowest(irr);
                mid   = m_isr | (8'd1 << l);
                ms    = 1'($urandom);
                ml    = 3'($urandom);
                e_end = mid;
                if (ms) e_end = e_end & ~(8'd1 << ml);
                if (aeoi) e_end = e_end & ~(8'd1 << l);
                do_ack(8'd1 << l, mid, {vb, 3'(l)}, e_end, ms, ml);
                m_isr = e_end;
                $display("rnd %0d ack lvl=%0d isr=%02h", it, l, isr);
            end else begin
                irr = 8'h00;
                step();
                $display("rnd %0d no request isr=%02h", it, isr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
